// File: rtl/sru_pkg.sv
// rtl/sru_pkg.sv - shared types for the shift register unit
package sru_pkg;

    typedef enum logic {S_IDLE, S_SHIFT} sru_state_t;
    typedef enum logic {DIR_L, DIR_R} sru_dir_t;

endpackage

// File: rtl/shift_register_unit_if.sv
// rtl/shift_register_unit_if.sv - command and status bundle of the shift register unit
interface shift_register_unit_if #(
    parameter int WIDTH = 10,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             init;
    logic             zero;
    logic             ld;
    logic             shl;
    logic             shr;
    logic [CNT_W-1:0] amt;
    logic             sin;
    logic [WIDTH-1:0] pi;
    logic [WIDTH-1:0] po;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output init, zero, ld, shl, shr, amt, sin, pi,
        input  po, sout, busy, done
    );

    modport slave (
        input  init, zero, ld, shl, shr, amt, sin, pi,
        output po, sout, busy, done
    );
endinterface

// File: rtl/shift_step_counter.sv
// rtl/shift_step_counter.sv - remaining-step down-counter with saturating load
module shift_step_counter #(
    parameter int WIDTH = 10,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clr,
    input  logic             dec,
    input  logic [CNT_W-1:0] amt,
    output logic [CNT_W-1:0] n_sat,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);
    localparam logic [CNT_W-1:0] WMAX = CNT_W'(WIDTH);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        n_sat = (amt > WMAX) ? WMAX : amt;
    end

    // The step issued at load time counts as the first one, so n-1 remain.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = (n_sat == '0) ? '0 : n_sat - CNT_W'(1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/shift_register_unit.sv
// rtl/shift_register_unit.sv - load/init/clear register with autonomous multi-bit serial shifting
module shift_register_unit
    import sru_pkg::*;
#(
    parameter int               WIDTH    = 10,
    parameter logic [WIDTH-1:0] INIT_VAL = 10'b01_0000_0000,
    parameter int               CNT_W    = $clog2(WIDTH + 1)
) (
    input logic                  clk,
    input logic                  rst,
    shift_register_unit_if.slave bus
);
    sru_state_t       state_q, state_d;
    sru_dir_t         dir_q, dir_d;
    logic [WIDTH-1:0] po_q, po_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;
    logic             sin_q, sin_d;

    logic             cnt_load, cnt_clr, cnt_dec;
    logic [CNT_W-1:0] n_sat, cnt;
    logic             last;
    logic             step;
    logic             step_sin;
    sru_dir_t         step_dir;

    shift_step_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .clr   (cnt_clr),
        .dec   (cnt_dec),
        .amt   (bus.amt),
        .n_sat (n_sat),
        .cnt   (cnt),
        .last  (last)
    );

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        po_d     = po_q;
        sout_d   = sout_q;
        done_d   = 1'b0;
        sin_d    = sin_q;
        cnt_load = 1'b0;
        cnt_clr  = 1'b0;
        cnt_dec  = 1'b0;
        step     = 1'b0;
        step_sin = sin_q;
        step_dir = dir_q;

        if (state_q == S_IDLE) begin
            if (bus.init) begin
                po_d = INIT_VAL;
            end else if (bus.zero) begin
                po_d = '0;
            end else if (bus.ld) begin
                po_d = bus.pi;
            end else if (bus.shl || bus.shr) begin
                dir_d    = bus.shl ? DIR_L : DIR_R;
                sin_d    = bus.sin;
                step_dir = dir_d;
                step_sin = bus.sin;
                cnt_load = 1'b1;
                if (n_sat == '0) begin
                    done_d = 1'b1;
                end else begin
                    step = 1'b1;
                    if (n_sat == CNT_W'(1)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
        end else begin
            // init/zero abort the running shift without a done pulse.
            if (bus.init || bus.zero) begin
                po_d    = bus.init ? INIT_VAL : '0;
                state_d = S_IDLE;
                cnt_clr = 1'b1;
            end else begin
                step    = 1'b1;
                cnt_dec = 1'b1;
                if (last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        end

        if (step) begin
            if (step_dir == DIR_L) begin
                po_d   = {po_q[WIDTH-2:0], step_sin};
                sout_d = po_q[WIDTH-1];
            end else begin
                po_d   = {step_sin, po_q[WIDTH-1:1]};
                sout_d = po_q[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_L;
            po_q    <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            sin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            po_q    <= po_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
            sin_q   <= sin_d;
        end
    end

    assign bus.po   = po_q;
    assign bus.sout = sout_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q == S_SHIFT);
endmodule

// File: tb/tb_shift_register_unit.sv
// tb/tb_shift_register_unit.sv - directed self-checking bench for shift_register_unit
module tb_shift_register_unit;
    localparam int WIDTH = 10;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    shift_register_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_register_unit #(
        .WIDTH    (WIDTH),
        .INIT_VAL (10'b01_0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cmds();
        bus.init = 1'b0;
        bus.zero = 1'b0;
        bus.ld   = 1'b0;
        bus.shl  = 1'b0;
        bus.shr  = 1'b0;
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        bus.ld = 1'b1;
        bus.pi = v;
        tick();
        clr_cmds();
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus.po !== 10'h000) begin errors++; $display("FAIL reset_po got %h want %h", bus.po, 10'h000); end
        checks++; if ({bus.sout, bus.busy, bus.done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {bus.sout, bus.busy, bus.done}); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        load(10'h2AA);
        checks++; if (bus.po !== 10'h2AA) begin errors++; $display("FAIL ld_po got %h want %h", bus.po, 10'h2AA); end
        bus.shl = 1'b1; bus.amt = 4'd8; bus.sin = 1'b1;
        tick();
        clr_cmds();
        checks++; if ({bus.po, bus.sout, bus.busy} !== {10'h155, 1'b1, 1'b1}) begin errors++; $display("FAIL pre_reset_shift got %h/%b/%b want 155/1/1", bus.po, bus.sout, bus.busy); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({bus.po, bus.sout, bus.busy, bus.done} !== 13'h0) begin errors++; $display("FAIL async_reset got %h/%b/%b/%b want 0/0/0/0", bus.po, bus.sout, bus.busy, bus.done); end
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        checks++; if ({bus.po, bus.sout, bus.busy, bus.done} !== 13'h0) begin errors++; $display("FAIL post_reset_hold got %h/%b/%b/%b want 0/0/0/0", bus.po, bus.sout, bus.busy, bus.done); end
    endtask

    task automatic test_priority();
        bus.init = 1'b1; bus.zero = 1'b1; bus.ld = 1'b1; bus.pi = 10'h3FF;
        tick();
        checks++; if (bus.po !== 10'h100) begin errors++; $display("FAIL prio_init got %h want %h", bus.po, 10'h100); end
        bus.init = 1'b0;
        tick();
        clr_cmds();
        checks++; if (bus.po !== 10'h000) begin errors++; $display("FAIL prio_zero got %h want %h", bus.po, 10'h000); end
    endtask

    task automatic test_left_shift();
        int busy_cnt = 0;
        int done_cnt = 0;
        load(10'h005);
        bus.shl = 1'b1; bus.amt = 4'd3; bus.sin = 1'b1;
        tick();
        clr_cmds();
        bus.sin = 1'b0;
        for (int i = 0; i < 6; i++) begin
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.done);
            if (bus.done) begin
                checks++; if ({bus.po, bus.sout} !== {10'h02F, 1'b0}) begin errors++; $display("FAIL shl_result got %h/%b want 02F/0", bus.po, bus.sout); end
            end
            tick();
        end
        checks++; if (busy_cnt != 2) begin errors++; $display("FAIL shl_busy_cycles got %0d want 2", busy_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL shl_done_cycles got %0d want 1", done_cnt); end
    endtask

    task automatic test_right_saturate();
        int busy_cnt = 0;
        int done_cnt = 0;
        load(10'h3FF);
        bus.shr = 1'b1; bus.amt = 4'd15; bus.sin = 1'b0;
        tick();
        clr_cmds();
        bus.sin = 1'b1;
        for (int i = 0; i < 14; i++) begin
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.done);
            tick();
        end
        checks++; if (busy_cnt != 9) begin errors++; $display("FAIL shr_busy_cycles got %0d want 9", busy_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL shr_done_cycles got %0d want 1", done_cnt); end
        checks++; if ({bus.po, bus.sout} !== {10'h000, 1'b1}) begin errors++; $display("FAIL shr_result got %h/%b want 000/1", bus.po, bus.sout); end
        load(10'h0AA);
        checks++; if ({bus.po, bus.sout} !== {10'h0AA, 1'b1}) begin errors++; $display("FAIL ld_keeps_sout got %h/%b want 0AA/1", bus.po, bus.sout); end
    endtask

    task automatic test_abort();
        int done_cnt = 0;
        load(10'h001);
        bus.shl = 1'b1; bus.amt = 4'd8; bus.sin = 1'b1;
        tick();
        clr_cmds();
        bus.ld = 1'b1; bus.pi = 10'h3FF; bus.shr = 1'b1; bus.amt = 4'd2; bus.sin = 1'b0;
        tick();
        clr_cmds();
        checks++; if ({bus.po, bus.busy} !== {10'h007, 1'b1}) begin errors++; $display("FAIL busy_ignores_cmds got %h/%b want 007/1", bus.po, bus.busy); end
        tick();
        checks++; if ({bus.po, bus.busy} !== {10'h00F, 1'b1}) begin errors++; $display("FAIL third_busy_cycle got %h/%b want 00F/1", bus.po, bus.busy); end
        bus.zero = 1'b1;
        tick();
        clr_cmds();
        checks++; if ({bus.po, bus.busy, bus.done} !== {10'h000, 1'b0, 1'b0}) begin errors++; $display("FAIL abort got %h/%b/%b want 000/0/0", bus.po, bus.busy, bus.done); end
        for (int i = 0; i < 8; i++) begin
            done_cnt += int'(bus.done) + int'(bus.busy);
            tick();
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
    endtask

    task automatic test_edge_amounts();
        load(10'h155);
        bus.shl = 1'b1; bus.amt = 4'd0; bus.sin = 1'b1;
        tick();
        clr_cmds();
        checks++; if ({bus.po, bus.busy, bus.done} !== {10'h155, 1'b0, 1'b1}) begin errors++; $display("FAIL amt0 got %h/%b/%b want 155/0/1", bus.po, bus.busy, bus.done); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL amt0_done_width got %b want 0", bus.done); end
        bus.shr = 1'b1; bus.amt = 4'd1; bus.sin = 1'b1;
        tick();
        clr_cmds();
        checks++; if ({bus.po, bus.sout, bus.busy, bus.done} !== {10'h2AA, 1'b1, 1'b0, 1'b1}) begin errors++; $display("FAIL amt1 got %h/%b/%b/%b want 2AA/1/0/1", bus.po, bus.sout, bus.busy, bus.done); end
        bus.shl = 1'b1; bus.amt = 4'd2; bus.sin = 1'b0;
        tick();
        clr_cmds();
        checks++; if ({bus.po, bus.sout, bus.busy, bus.done} !== {10'h154, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL b2b_step1 got %h/%b/%b/%b want 154/1/1/0", bus.po, bus.sout, bus.busy, bus.done); end
        tick();
        checks++; if ({bus.po, bus.sout, bus.busy, bus.done} !== {10'h2A8, 1'b0, 1'b0, 1'b1}) begin errors++; $display("FAIL b2b_step2 got %h/%b/%b/%b want 2A8/0/0/1", bus.po, bus.sout, bus.busy, bus.done); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_width got %b want 0", bus.done); end
    endtask

    initial begin
        clr_cmds();
        bus.amt = '0;
        bus.sin = 1'b0;
        bus.pi  = '0;
        test_reset();
        test_priority();
        test_left_shift();
        test_right_saturate();
        test_abort();
        test_edge_amounts();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
